mem_exec_unit: RTL and testbench
================================

# mem_exec_unit

Single-issue memory execute unit: consumer end of the memory issue queue. Accepts one issued load/store `micro_op_t` plus its PRF operand values, drives `ex_busy` back to the queue, runs one valid/ready request to the data memory port, waits for load data, aligns and extends it, and presents a one-cycle writeback to the ROB/PRF stage.

## Interface
- `XLEN`, 32, data and address width
- `clock`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low (0 = reset at next posedge)
- `clear`  in  1  pipeline flush; drops the in-flight uop
- `uop_in`  in  micro_op_t  issued uop (uses `valid`, `mem_type`, `mem_size`, `mem_signed`, `imm`, `rd_prf_int_index`, `rob_index`)
- `rs1_value`  in  XLEN  base operand, valid with `uop_in`
- `rs2_value`  in  XLEN  store data, valid with `uop_in`
- `ex_busy`  out  1  to the issue queue; 1 = do not issue
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  XLEN  word-aligned address (`addr[1:0]` forced to 0)
- `mem_req_we`  out  1  1 = store
- `mem_req_wdata`  out  XLEN  store data placed in byte lanes
- `mem_req_strb`  out  XLEN/8  byte enables (all 0 for loads)
- `mem_resp_valid`  in  1  load data valid (one pulse per accepted load)
- `mem_resp_data`  in  XLEN  raw word
- `wb_valid`  out  1  writeback pulse
- `wb_uop`  out  micro_op_t  completed uop
- `wb_data`  out  XLEN  extended load data; 0 for stores/exceptions
- `wb_misaligned`  out  1  address not naturally aligned

## Operation
- States: IDLE, REQ, RESP, WB, DRAIN. `ex_busy = (state != IDLE)`.
- IDLE: if `uop_in.valid & ~clear`, latch uop, `addr = rs1_value + sext(imm)` (mod 2^XLEN), `rs2_value`, lane/strobe; go REQ, or WB with `wb_misaligned=1` if half at odd address or word with `addr[1:0]!=0` (no memory access).
- `uop_in.valid` while `ex_busy=1` is a protocol violation; ignored.
- REQ: `mem_req_valid = ~clear`. On handshake: store → WB; load → RESP. Outputs held stable until handshake.
- RESP: on `mem_resp_valid` register `data >> (8*addr[1:0])`, extend per `mem_size`/`mem_signed` (B/H/W); go WB.
- WB: `wb_valid=1` for exactly one cycle, `wb_uop`/`wb_data` from registers; → IDLE. No backpressure.
- Store lanes: B → `rs2[7:0]` replicated ×4, strb `0001<<addr[1:0]`; H → `rs2[15:0]` ×2, strb `0011<<addr[1:0]`; W → `rs2`, strb `1111`.
- clear: REQ/WB/IDLE → IDLE next cycle, no handshake in the clear cycle, no `wb_valid`. RESP → DRAIN (load outstanding). Clear in same cycle as `mem_resp_valid` in RESP → IDLE.
- DRAIN: wait `mem_resp_valid`, discard, → IDLE. Further `clear` ignored.
- `mem_resp_valid` in IDLE/REQ/WB is ignored.

## Timing
- Reset: state IDLE, all outputs 0, `wb_uop` = 0, `ex_busy=0`; a response arriving after reset is ignored.
- Accept at edge E0; `mem_req_valid` in cycle after E0.
- Store, ready=1: handshake E1, `wb_valid` cycle after E1, `ex_busy` low after E2 (3 edges busy).
- Load, response in cycle k: `wb_valid` cycle k+1.
- Misaligned: `wb_valid` cycle after E0.
- Back-to-back: next uop accepted on the edge leaving WB→IDLE +1 (one idle cycle minimum).

## Structure
- `mem_exec_state_t` enum and `mem_size` encodings (B/H/W) in `micro_op.svh` alongside `MEM_LD`/`MEM_ST`.
- Sub-module `mem_data_align`: combinational store lane/strobe generation and load shift/extension; FSM and registers in `mem_exec_unit`.

## Test plan
- Store W, rs1=0x1000, imm=4, rs2=0xDEADBEEF, ready=1 → addr 0x1004, strb 1111, wdata 0xDEADBEEF; `wb_valid` 2 cycles after accept, data 0.
- Load B signed, addr 0x2003, resp 0x80FF_FF00 after 3 cycles → `wb_data`=0xFFFFFF80; unsigned → 0x00000080.
- Load H at 0x2001 → no `mem_req_valid`, `wb_valid` next cycle with `wb_misaligned=1`, `ex_busy` low after.
- `mem_req_ready`=0 for 4 cycles then 1 → addr/wdata/strb stable throughout, exactly one handshake.
- `clear` in RESP; resp 2 cycles later → no `wb_valid`, `ex_busy` held until resp, then 0; next load completes normally.
- `reset`=0 in RESP, resp arrives after reset released → ignored, all outputs 0, new uop accepted.

Source files
------------

// File: rtl/mem_exec_unit_pkg.sv
// Shared types for the memory execute unit: uop layout, memory op/size encodings, FSM states.
// Pure declarations; no timing or flow-control behaviour lives here.
package mem_exec_unit_pkg;
   localparam int XLEN  = 32;
   localparam int STRBW = XLEN / 8;
   localparam int IMM_W = 12;
   localparam int PRF_W = 6;
   localparam int ROB_W = 5;

   typedef enum logic {MEM_LD = 1'b0, MEM_ST = 1'b1} mem_type_t;
   typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_t;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RESP, ST_WB, ST_DRAIN} mem_exec_state_t;

   typedef struct packed {
      logic                    valid;
      mem_type_t               mem_type;
      mem_size_t               mem_size;
      logic                    mem_signed;
      logic [IMM_W-1:0]        imm;
      logic [PRF_W-1:0]        rd_prf_int_index;
      logic [ROB_W-1:0]        rob_index;
   } micro_op_t;

   // Halves need an even address, words a 4-byte aligned one.
   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
      case (size)
         MEM_B:   return 1'b0;
         MEM_H:   return lo[0];
         default: return lo != 2'b00;
      endcase
   endfunction
endpackage

// File: rtl/mem_data_align.sv
// Byte-lane steering: store data/strobe replication and load shift plus sign/zero extension.
// Purely combinational, zero latency, no flow control.
module mem_data_align
   import mem_exec_unit_pkg::*;
(
   input  mem_size_t         st_size,
   input  logic [1:0]        st_lo,
   input  logic [XLEN-1:0]   st_data,
   output logic [XLEN-1:0]   st_wdata,
   output logic [STRBW-1:0]  st_strb,
   input  mem_size_t         ld_size,
   input  logic              ld_signed,
   input  logic [1:0]        ld_lo,
   input  logic [XLEN-1:0]   ld_raw,
   output logic [XLEN-1:0]   ld_data
);
   logic [XLEN-1:0] shifted;

   always_comb begin
      st_wdata = st_data;
      st_strb  = 4'b1111;
      case (st_size)
         MEM_B: begin
            st_wdata = {4{st_data[7:0]}};
            st_strb  = 4'b0001 << st_lo;
         end
         MEM_H: begin
            st_wdata = {2{st_data[15:0]}};
            st_strb  = 4'b0011 << st_lo;
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = ld_raw >> {ld_lo, 3'b000};
      ld_data = shifted;
      case (ld_size)
         MEM_B:   ld_data = {{(XLEN-8){ld_signed & shifted[7]}}, shifted[7:0]};
         MEM_H:   ld_data = {{(XLEN-16){ld_signed & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_exec_unit.sv
// Single-issue load/store execute: accept uop, one memory request, wait for load data, one-cycle writeback.
// Latency: store 2 cycles, load resp+1, misaligned 1; ex_busy holds off issue; writeback has no backpressure.
module mem_exec_unit
   import mem_exec_unit_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  micro_op_t         uop_in,
   input  logic [XLEN-1:0]   rs1_value,
   input  logic [XLEN-1:0]   rs2_value,
   output logic              ex_busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_we,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [STRBW-1:0]  mem_req_strb,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_data,
   output logic              wb_valid,
   output micro_op_t         wb_uop,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_misaligned
);
   mem_exec_state_t state, state_nxt;
   micro_op_t       uop_q;
   logic [XLEN-1:0] addr_q, wdata_q, data_q;
   logic [STRBW-1:0] strb_q;
   logic            misal_q;

   logic [XLEN-1:0] eff_addr, st_wdata, ld_data;
   logic [STRBW-1:0] st_strb;
   logic            accept, misal_in;

   assign eff_addr = rs1_value + {{(XLEN-IMM_W){uop_in.imm[IMM_W-1]}}, uop_in.imm};
   assign accept   = (state == ST_IDLE) & uop_in.valid & ~clear;
   assign misal_in = is_misaligned(uop_in.mem_size, eff_addr[1:0]);

   mem_data_align u_align (
      .st_size   (uop_in.mem_size),
      .st_lo     (eff_addr[1:0]),
      .st_data   (rs2_value),
      .st_wdata  (st_wdata),
      .st_strb   (st_strb),
      .ld_size   (uop_q.mem_size),
      .ld_signed (uop_q.mem_signed),
      .ld_lo     (addr_q[1:0]),
      .ld_raw    (mem_resp_data),
      .ld_data   (ld_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = misal_in ? ST_WB : ST_REQ;
         ST_REQ: begin
            if (clear)              state_nxt = ST_IDLE;
            else if (mem_req_ready) state_nxt = (uop_q.mem_type == MEM_ST) ? ST_WB : ST_RESP;
         end
         // A flushed load still owes us a response, so swallow it before going idle.
         ST_RESP: begin
            if (clear)               state_nxt = mem_resp_valid ? ST_IDLE : ST_DRAIN;
            else if (mem_resp_valid) state_nxt = ST_WB;
         end
         ST_WB:    state_nxt = ST_IDLE;
         ST_DRAIN: if (mem_resp_valid) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= ST_IDLE;
         uop_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         data_q  <= '0;
         misal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            uop_q   <= uop_in;
            addr_q  <= eff_addr;
            wdata_q <= st_wdata;
            strb_q  <= (uop_in.mem_type == MEM_ST) ? st_strb : '0;
            data_q  <= '0;
            misal_q <= misal_in;
         end else if (state == ST_RESP && mem_resp_valid && !clear) begin
            data_q <= ld_data;
         end
      end
   end

   assign ex_busy       = (state != ST_IDLE);
   assign mem_req_valid = (state == ST_REQ) & ~clear;
   assign mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign mem_req_we    = (uop_q.mem_type == MEM_ST);
   assign mem_req_wdata = wdata_q;
   assign mem_req_strb  = strb_q;
   assign wb_valid      = (state == ST_WB) & ~clear;
   assign wb_uop        = uop_q;
   assign wb_data       = data_q;
   assign wb_misaligned = wb_valid & misal_q;
endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed bench for mem_exec_unit: hand-computed expectations checked with immediate assertions.
module tb_mem_exec_unit;
   import mem_exec_unit_pkg::*;

   logic             clock = 1'b0;
   logic             reset, clear;
   micro_op_t        uop_in;
   logic [XLEN-1:0]  rs1_value, rs2_value;
   logic             ex_busy, mem_req_valid, mem_req_ready, mem_req_we;
   logic [XLEN-1:0]  mem_req_addr, mem_req_wdata;
   logic [STRBW-1:0] mem_req_strb;
   logic             mem_resp_valid;
   logic [XLEN-1:0]  mem_resp_data;
   logic             wb_valid, wb_misaligned;
   micro_op_t        wb_uop;
   logic [XLEN-1:0]  wb_data;

   int checks = 0;
   int fails  = 0;

   always #5 clock = ~clock;

   mem_exec_unit dut (
      .clock(clock), .reset(reset), .clear(clear), .uop_in(uop_in),
      .rs1_value(rs1_value), .rs2_value(rs2_value), .ex_busy(ex_busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata), .mem_req_strb(mem_req_strb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .wb_valid(wb_valid), .wb_uop(wb_uop), .wb_data(wb_data),
      .wb_misaligned(wb_misaligned)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   function automatic micro_op_t mk_uop(input mem_type_t t, input mem_size_t s, input logic sgn,
                                        input logic [IMM_W-1:0] imm, input logic [ROB_W-1:0] rob);
      micro_op_t u;
      u.valid            = 1'b1;
      u.mem_type         = t;
      u.mem_size         = s;
      u.mem_signed       = sgn;
      u.imm              = imm;
      u.rd_prf_int_index = PRF_W'(rob) + 6'd1;
      u.rob_index        = rob;
      return u;
   endfunction

   initial begin
      reset = 1'b0; clear = 1'b0; uop_in = '0; rs1_value = '0; rs2_value = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      cyc(); cyc(); #1;
      chk("rst_busy", ex_busy, 0);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_uop", wb_uop, 0);
      chk("rst_strb", mem_req_strb, 0);
      reset = 1'b1;
      cyc();

      // Store word, ready high
      uop_in = mk_uop(MEM_ST, MEM_W, 1'b0, 12'd4, 5'd3);
      rs1_value = 32'h1000; rs2_value = 32'hDEADBEEF; mem_req_ready = 1'b1; #1;
      chk("sw_idle_busy", ex_busy, 0);
      cyc(); uop_in = '0; #1;
      chk("sw_req_valid", mem_req_valid, 1);
      chk("sw_addr", mem_req_addr, 32'h1004);
      chk("sw_we", mem_req_we, 1);
      chk("sw_strb", mem_req_strb, 4'hF);
      chk("sw_wdata", mem_req_wdata, 32'hDEADBEEF);
      cyc(); #1;
      chk("sw_wb_valid", wb_valid, 1);
      chk("sw_wb_data", wb_data, 0);
      chk("sw_wb_mis", wb_misaligned, 0);
      chk("sw_wb_rob", wb_uop.rob_index, 3);
      chk("sw_req_after", mem_req_valid, 0);
      cyc(); #1;
      chk("sw_busy_end", ex_busy, 0);
      chk("sw_wb_end", wb_valid, 0);

      // Signed byte load at 0x2003 via negative immediate, response 3 cycles after handshake
      uop_in = mk_uop(MEM_LD, MEM_B, 1'b1, 12'hFFF, 5'd7);
      rs1_value = 32'h2004; #1;
      cyc(); uop_in = '0; #1;
      chk("lbs_req_valid", mem_req_valid, 1);
      chk("lbs_addr", mem_req_addr, 32'h2000);
      chk("lbs_we", mem_req_we, 0);
      chk("lbs_strb", mem_req_strb, 0);
      cyc(); mem_req_ready = 1'b0; #1;
      chk("lbs_resp_req", mem_req_valid, 0);
      chk("lbs_resp_busy", ex_busy, 1);
      cyc(); #1;
      chk("lbs_resp_wb", wb_valid, 0);
      mem_resp_valid = 1'b1; mem_resp_data = 32'h80FFFF00; #1;
      cyc(); mem_resp_valid = 1'b0; #1;
      chk("lbs_wb_valid", wb_valid, 1);
      chk("lbs_wb_data", wb_data, 32'hFFFFFF80);
      chk("lbs_wb_rd", wb_uop.rd_prf_int_index, 8);
      cyc(); #1;
      chk("lbs_busy_end", ex_busy, 0);

      // Unsigned byte load, same address, immediate response
      uop_in = mk_uop(MEM_LD, MEM_B, 1'b0, 12'd3, 5'd8);
      rs1_value = 32'h2000; mem_req_ready = 1'b1; #1;
      cyc(); uop_in = '0; #1;
      cyc(); mem_resp_valid = 1'b1; mem_resp_data = 32'h80FFFF00; #1;
      cyc(); mem_resp_valid = 1'b0; #1;
      chk("lbu_wb_valid", wb_valid, 1);
      chk("lbu_wb_data", wb_data, 32'h00000080);
      cyc();

      // Misaligned half load: no memory access
      uop_in = mk_uop(MEM_LD, MEM_H, 1'b1, 12'd1, 5'd9);
      rs1_value = 32'h2000; #1;
      cyc(); uop_in = '0; #1;
      chk("lhm_req_valid", mem_req_valid, 0);
      chk("lhm_wb_valid", wb_valid, 1);
      chk("lhm_wb_mis", wb_misaligned, 1);
      chk("lhm_wb_data", wb_data, 0);
      cyc(); #1;
      chk("lhm_busy_end", ex_busy, 0);

      // Store half at 0x1002 held off by ready=0 for 4 cycles
      uop_in = mk_uop(MEM_ST, MEM_H, 1'b0, 12'd2, 5'd10);
      rs1_value = 32'h1000; rs2_value = 32'h1234ABCD; mem_req_ready = 1'b0; #1;
      cyc(); uop_in = '0; #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("shs_valid%0d", i), mem_req_valid, 1);
         chk($sformatf("shs_addr%0d", i), mem_req_addr, 32'h1000);
         chk($sformatf("shs_wdata%0d", i), mem_req_wdata, 32'hABCDABCD);
         chk($sformatf("shs_strb%0d", i), mem_req_strb, 4'hC);
         cyc(); #1;
      end
      mem_req_ready = 1'b1; #1;
      cyc(); #1;
      chk("shs_wb_valid", wb_valid, 1);
      chk("shs_one_hs", mem_req_valid, 0);
      cyc();

      // Flush while a load is outstanding; response arrives 2 cycles later
      uop_in = mk_uop(MEM_LD, MEM_W, 1'b0, 12'd0, 5'd11);
      rs1_value = 32'h4000; #1;
      cyc(); uop_in = '0; #1;
      cyc(); clear = 1'b1; #1;
      chk("clr_req_valid", mem_req_valid, 0);
      cyc(); clear = 1'b0; #1;
      chk("clr_drain_busy", ex_busy, 1);
      chk("clr_drain_wb", wb_valid, 0);
      cyc(); #1;
      chk("clr_drain_busy2", ex_busy, 1);
      mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678; #1;
      cyc(); mem_resp_valid = 1'b0; #1;
      chk("clr_no_wb", wb_valid, 0);
      chk("clr_busy_end", ex_busy, 0);
      uop_in = mk_uop(MEM_LD, MEM_W, 1'b0, 12'd8, 5'd12); #1;
      cyc(); uop_in = '0; #1;
      cyc(); mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D; #1;
      cyc(); mem_resp_valid = 1'b0; #1;
      chk("post_clr_wb", wb_valid, 1);
      chk("post_clr_data", wb_data, 32'hCAFEF00D);
      chk("post_clr_rob", wb_uop.rob_index, 12);
      cyc();

      // Reset during RESP; late response must be ignored
      uop_in = mk_uop(MEM_LD, MEM_H, 1'b0, 12'd2, 5'd13);
      rs1_value = 32'h5000; #1;
      cyc(); uop_in = '0; #1;
      cyc(); reset = 1'b0; #1;
      cyc(); reset = 1'b1; #1;
      chk("rr_busy", ex_busy, 0);
      chk("rr_req_valid", mem_req_valid, 0);
      chk("rr_wb_uop", wb_uop, 0);
      chk("rr_addr", mem_req_addr, 0);
      chk("rr_wdata", mem_req_wdata, 0);
      mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF0000; #1;
      cyc(); mem_resp_valid = 1'b0; #1;
      chk("rr_late_wb", wb_valid, 0);
      chk("rr_late_busy", ex_busy, 0);
      uop_in = mk_uop(MEM_ST, MEM_B, 1'b0, 12'd1, 5'd14);
      rs1_value = 32'h3000; rs2_value = 32'h00000055; #1;
      cyc(); uop_in = '0; #1;
      chk("sb_req_valid", mem_req_valid, 1);
      chk("sb_addr", mem_req_addr, 32'h3000);
      chk("sb_wdata", mem_req_wdata, 32'h55555555);
      chk("sb_strb", mem_req_strb, 4'h2);
      cyc(); #1;
      chk("sb_wb_valid", wb_valid, 1);
      cyc();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
